// File: rtl/lsu_model_pkg.sv
// Shared types and sizing helpers for the LSU issue-side handshake model.
// Holds the load FSM state encoding, the default store depth and pointer/count widths.
package lsu_model_pkg;

    typedef enum logic {
        LD_IDLE    = 1'b0,
        LD_PENDING = 1'b1
    } ld_state_e;

    localparam int unsigned STORE_DEPTH_DEF = 2;

    // A single-entry queue still needs a 1-bit pointer.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lsu_store_queue.sv
// Circular FIFO of outstanding store addresses; push/pop take effect at the clock edge, state visible next cycle.
// No internal backpressure: push is ignored when full unless paired with a pop; pop is ignored when empty.
module lsu_store_queue
    import lsu_model_pkg::*;
#(
    parameter int unsigned DEPTH  = STORE_DEPTH_DEF,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned PTR_W = ptr_w(DEPTH),
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[tail_q] = push_addr;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = ptr_inc(head_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lsu_model.sv
// Issue-side LSU model: one load in flight plus a store queue; ready_o is registered-state only, effects seen next cycle.
// Offers while ready_o=0 are dropped silently; responses with nothing outstanding are ignored.
module lsu_model
    import lsu_model_pkg::*;
#(
    parameter int unsigned STORE_DEPTH = STORE_DEPTH_DEF,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] instr_i,
    input  logic              is_load_i,
    input  logic              instr_valid_i,
    input  logic              store_mem_resp_i,
    input  logic              load_mem_resp_i,
    output logic              ready_o
);

    localparam int unsigned CNT_W = cnt_w(STORE_DEPTH);

    ld_state_e        ld_state_q, ld_state_d;
    logic             accept;
    logic             st_push;
    logic             sq_full;
    logic             sq_empty;
    logic [CNT_W-1:0] sq_count;

    assign ready_o = (ld_state_q == LD_IDLE) && (sq_count < CNT_W'(STORE_DEPTH));
    // Gate with valid first so X on is_load_i never leaks into state when idle.
    assign accept  = instr_valid_i && ready_o;
    assign st_push = accept && !is_load_i;

    always_comb begin
        ld_state_d = ld_state_q;
        case (ld_state_q)
            LD_IDLE:    if (accept && is_load_i) ld_state_d = LD_PENDING;
            LD_PENDING: if (load_mem_resp_i)     ld_state_d = LD_IDLE;
            default:    ld_state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_state_q <= LD_IDLE;
        end else begin
            ld_state_q <= ld_state_d;
        end
    end

    lsu_store_queue #(
        .DEPTH  (STORE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (st_push),
        .pop       (store_mem_resp_i),
        .push_addr (instr_i),
        .full      (sq_full),
        .empty     (sq_empty),
        .count     (sq_count)
    );

    a_full_not_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(sq_full && sq_empty));

endmodule

// File: tb/tb_lsu_model.sv
// Directed bench for lsu_model: hand-computed ready_o, store count and queued addresses per scenario.
module tb_lsu_model;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        is_load_i;
    logic        instr_valid_i;
    logic        store_mem_resp_i;
    logic        load_mem_resp_i;
    logic        ready_o;

    int n_cmp = 0;
    int n_err = 0;

    lsu_model #(
        .STORE_DEPTH (2),
        .ADDR_W      (32)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .instr_i          (instr_i),
        .is_load_i        (is_load_i),
        .instr_valid_i    (instr_valid_i),
        .store_mem_resp_i (store_mem_resp_i),
        .load_mem_resp_i  (load_mem_resp_i),
        .ready_o          (ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge, then clear pulses and settle.
    task automatic tick();
        @(posedge clk_i);
        #1;
        instr_valid_i    = 1'b0;
        store_mem_resp_i = 1'b0;
        load_mem_resp_i  = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic [31:0] addr);
        instr_valid_i = 1'b1;
        is_load_i     = ld;
        instr_i       = addr;
    endtask

    initial begin
        rst_i            = 1'b1;
        instr_i          = 'x;
        is_load_i        = 1'bx;
        instr_valid_i    = 1'b0;
        store_mem_resp_i = 1'b0;
        load_mem_resp_i  = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        rst_i = 1'b0;
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_count", dut.sq_count, 0);

        store_mem_resp_i = 1'b1;
        load_mem_resp_i  = 1'b1;
        tick();
        check_eq("spurious_ready", ready_o, 1);
        check_eq("spurious_count", dut.sq_count, 0);

        // Single load, held pending for three cycles
        issue(1'b1, 32'hcad);
        tick();
        check_eq("ld_busy", ready_o, 0);
        tick();
        tick();
        tick();
        check_eq("ld_hold", ready_o, 0);
        load_mem_resp_i = 1'b1;
        tick();
        check_eq("ld_done", ready_o, 1);

        // Fill the store queue
        issue(1'b0, 32'hcad);
        tick();
        check_eq("st1_ready", ready_o, 1);
        check_eq("st1_count", dut.sq_count, 1);
        issue(1'b0, 32'hbee);
        tick();
        check_eq("st2_ready", ready_o, 0);
        check_eq("st2_count", dut.sq_count, 2);
        check_eq("st_addr0", dut.u_sq.mem_q[0], 32'hcad);
        check_eq("st_addr1", dut.u_sq.mem_q[1], 32'hbee);
        issue(1'b0, 32'h123);
        tick();
        check_eq("full_drop_count", dut.sq_count, 2);
        store_mem_resp_i = 1'b1;
        tick();
        check_eq("pop1_ready", ready_o, 1);
        check_eq("pop1_count", dut.sq_count, 1);
        store_mem_resp_i = 1'b1;
        tick();
        check_eq("pop2_count", dut.sq_count, 0);

        // Load overlapping an outstanding store, both responses together
        issue(1'b0, 32'hcad);
        tick();
        issue(1'b1, 32'hcad);
        tick();
        check_eq("mix_ready", ready_o, 0);
        check_eq("mix_count", dut.sq_count, 1);
        store_mem_resp_i = 1'b1;
        load_mem_resp_i  = 1'b1;
        tick();
        check_eq("mix_done_ready", ready_o, 1);
        check_eq("mix_done_count", dut.sq_count, 0);

        // Store offered while a load is pending is dropped
        issue(1'b1, 32'h40);
        tick();
        issue(1'b0, 32'h44);
        tick();
        check_eq("drop_count", dut.sq_count, 0);
        load_mem_resp_i = 1'b1;
        tick();
        check_eq("drop_after_count", dut.sq_count, 0);
        check_eq("drop_after_ready", ready_o, 1);

        // Simultaneous push and pop keeps the count
        issue(1'b0, 32'h50);
        tick();
        check_eq("pp_pre_count", dut.sq_count, 1);
        issue(1'b0, 32'h54);
        store_mem_resp_i = 1'b1;
        tick();
        check_eq("pp_count", dut.sq_count, 1);
        check_eq("pp_ready", ready_o, 1);
        store_mem_resp_i = 1'b1;
        tick();
        check_eq("pp_drain_count", dut.sq_count, 0);

        // Reset with a load pending and a store queued
        issue(1'b0, 32'h60);
        tick();
        issue(1'b1, 32'h64);
        tick();
        check_eq("mid_pre_ready", ready_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("mid_rst_ready", ready_o, 1);
        check_eq("mid_rst_count", dut.sq_count, 0);
        load_mem_resp_i = 1'b1;
        tick();
        check_eq("late_resp_ready", ready_o, 1);
        issue(1'b1, 32'h68);
        tick();
        check_eq("new_ld_busy", ready_o, 0);
        load_mem_resp_i = 1'b1;
        tick();
        check_eq("new_ld_done", ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
